sound_event_scheduler: RTL and testbench
========================================

Name: sound_event_scheduler

Overview:
- Sits directly upstream of the sound generator; takes the single-cycle game sound events (failure, success, eat, new_input, tick) from the game logic.
- Re-issues them as single-cycle pulses, at most one per frame, spaced so that each effect finishes before the next starts.
- Failure preempts everything.
- Without this block, back-to-back eats or an eat followed by a tick would be lost or truncated by the sound generator.

Parameters:
- HOLD_LONG, 24: frames reserved after dispatching success or eat (and after failure).
- HOLD_SHORT, 4: frames reserved after dispatching new_input or tick.
- EAT_MAX, 3: saturation value of the pending-eat counter (2-bit).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- vsync  in  1  raw VGA vsync level; the rising edge is detected internally.
- mute  in  1  level; while high, all pending events are discarded and nothing is dispatched.
- evt_failure  in  1  single-cycle event.
- evt_success  in  1  single-cycle event.
- evt_eat  in  1  single-cycle event.
- evt_new_input  in  1  single-cycle event.
- evt_tick  in  1  single-cycle event.
- snd_failure  out  1  single-cycle pulse to the sound generator.
- snd_success  out  1  single-cycle pulse to the sound generator.
- snd_eat  out  1  single-cycle pulse to the sound generator.
- snd_new_input  out  1  single-cycle pulse to the sound generator.
- snd_tick  out  1  single-cycle pulse to the sound generator.
- busy  out  1  high while gap counter != 0.
- overflow  out  1  single-cycle pulse when an eat is dropped because the counter is saturated.

Behaviour:
- Reset (async, rst=1):
  - All snd_* = 0; busy = 0; overflow = 0.
  - Pending flags = 0; eat_cnt = 0; gap = 0; prev_vsync = 0.
- Frame edge: vs_edge = vsync & !prev_vsync; prev_vsync is registered every cycle.
- Pending state, registered, visible the cycle after the event:
  - success_p: sticky flag.
  - eat_cnt: 0..EAT_MAX, +1 per evt_eat, saturating.
  - input_p: flag; multiple new_inputs coalesce into one.
  - tick_p: flag; multiple ticks coalesce into one.
- Eat overflow: if evt_eat arrives while eat_cnt == EAT_MAX and no eat is dispatched that cycle, the event is dropped and overflow pulses the next cycle.
- Failure path, independent of vsync and gap:
  - evt_failure at cycle n → snd_failure = 1 at n+1 only.
  - At n+1: gap = HOLD_LONG; all pending state cleared.
  - Other events arriving in cycle n are discarded.
- Normal dispatch is evaluated only in a cycle with vs_edge = 1 and mute = 0:
  - gap != 0: gap decrements by 1; no dispatch.
  - gap == 0: dispatch the highest pending by priority success > eat > new_input > tick.
  - The matching snd_* is high the next cycle for exactly one cycle.
  - The pending entry is consumed (flag cleared or eat_cnt − 1).
  - gap is loaded: HOLD_LONG for success/eat, HOLD_SHORT for new_input/tick.
  - Nothing pending: no action; gap stays 0.
- Spacing: after a long dispatch, the next dispatch occurs on the (HOLD_LONG+1)-th following vs_edge; for short dispatches, the (HOLD_SHORT+1)-th.
- Same-cycle arrival and consumption of one class:
  - eat: net eat_cnt unchanged (decrement then increment).
  - success/new_input/tick: flag remains set.
- Events arriving in a vs_edge cycle are not eligible until the next vs_edge.
- Only one snd_* is high in any cycle. If failure and a normal dispatch coincide, failure wins and the normal dispatch is cancelled with its pending state cleared.
- Mute:
  - While mute = 1, pending state is held at 0 and new events are ignored; failure is also suppressed.
  - gap continues to count down on vs_edge.
  - Deasserting mute is clean: nothing is replayed.
- Reset mid-operation: any in-flight pulse is cut immediately; after release the block behaves as from power-on.
- gap width: ceil(log2(HOLD_LONG+1)) bits, never wraps below 0.

Test Plan:
- Single eat: evt_eat with gap = 0 → snd_eat one cycle after the next vs_edge; busy high for the next 24 vs_edges; snd_eat asserted exactly once.
- Four evt_eat in consecutive cycles:
  - overflow pulses once (4th eat).
  - snd_eat on vs_edges k, k+25, k+50.
  - eat_cnt ends at 0.
- evt_tick and evt_success in the same cycle → snd_success first; snd_tick 25 vs_edges later; then gap = 4.
- Failure mid-gap: eat dispatched, then evt_failure 10 frames later → snd_failure the next cycle (not vsync-aligned); pending tick cleared; busy for 24 more vs_edges.
- Mute: mute = 1 while evt_eat/evt_failure are pulsed; release mute → no snd_* ever asserted; gap reaches 0.
- Async reset: assert rst during the snd_success cycle → outputs drop to 0 without a clock edge; after release, a single evt_tick → snd_tick on the first vs_edge.

Source files
------------

// File: rtl/sound_event_scheduler.sv
// Queues game sound events and re-issues them as one-cycle pulses, at most one per frame, spaced by a hold gap.
// Outputs are registered, one cycle after the deciding event; failure preempts everything; overflow flags dropped eats.
module sound_event_scheduler #(
  parameter int HOLD_LONG  = 24,
  parameter int HOLD_SHORT = 4,
  parameter int EAT_MAX    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic mute,
  input  logic evt_failure,
  input  logic evt_success,
  input  logic evt_eat,
  input  logic evt_new_input,
  input  logic evt_tick,
  output logic snd_failure,
  output logic snd_success,
  output logic snd_eat,
  output logic snd_new_input,
  output logic snd_tick,
  output logic busy,
  output logic overflow
);
  localparam int GW = $clog2(HOLD_LONG + 1);
  localparam int EW = $clog2(EAT_MAX + 1);
  localparam logic [GW-1:0] GAP_LONG  = GW'(HOLD_LONG);
  localparam logic [GW-1:0] GAP_SHORT = GW'(HOLD_SHORT);
  localparam logic [EW-1:0] EAT_SAT   = EW'(EAT_MAX);

  typedef enum logic [2:0] {SEL_NONE, SEL_SUCCESS, SEL_EAT, SEL_INPUT, SEL_TICK} sel_e;

  logic          prev_vsync_q, prev_vsync_d;
  logic          success_p_q, success_p_d;
  logic          input_p_q, input_p_d;
  logic          tick_p_q, tick_p_d;
  logic [EW-1:0] eat_cnt_q, eat_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [4:0]    snd_q, snd_d;
  logic          overflow_q, overflow_d;
  logic          vs_edge;
  logic [EW-1:0] eat_left;
  sel_e          sel;

  always_comb begin
    vs_edge      = vsync & ~prev_vsync_q;
    prev_vsync_d = vsync;
    sel          = SEL_NONE;
    if (vs_edge && gap_q == '0) begin
      if (success_p_q)           sel = SEL_SUCCESS;
      else if (eat_cnt_q != '0)  sel = SEL_EAT;
      else if (input_p_q)        sel = SEL_INPUT;
      else if (tick_p_q)         sel = SEL_TICK;
    end

    success_p_d = success_p_q;
    input_p_d   = input_p_q;
    tick_p_d    = tick_p_q;
    eat_cnt_d   = eat_cnt_q;
    eat_left    = eat_cnt_q;
    gap_d       = gap_q;
    snd_d       = '0;
    overflow_d  = 1'b0;

    if (vs_edge && gap_q != '0) gap_d = gap_q - GW'(1);

    if (mute) begin
      success_p_d = 1'b0;
      input_p_d   = 1'b0;
      tick_p_d    = 1'b0;
      eat_cnt_d   = '0;
    end else if (evt_failure) begin
      // Failure cancels any coinciding normal dispatch along with all pending work.
      success_p_d = 1'b0;
      input_p_d   = 1'b0;
      tick_p_d    = 1'b0;
      eat_cnt_d   = '0;
      snd_d[0]    = 1'b1;
      gap_d       = GAP_LONG;
    end else begin
      case (sel)
        SEL_SUCCESS: begin snd_d[1] = 1'b1; success_p_d = 1'b0; gap_d = GAP_LONG; end
        SEL_EAT:     begin snd_d[2] = 1'b1; eat_left = eat_cnt_q - EW'(1); gap_d = GAP_LONG; end
        SEL_INPUT:   begin snd_d[3] = 1'b1; input_p_d = 1'b0; gap_d = GAP_SHORT; end
        SEL_TICK:    begin snd_d[4] = 1'b1; tick_p_d = 1'b0; gap_d = GAP_SHORT; end
        default: ;
      endcase
      // Arrivals are applied after consumption so a same-cycle event survives.
      success_p_d = success_p_d | evt_success;
      input_p_d   = input_p_d | evt_new_input;
      tick_p_d    = tick_p_d | evt_tick;
      eat_cnt_d   = eat_left;
      if (evt_eat) begin
        if (eat_left == EAT_SAT) overflow_d = 1'b1;
        else                     eat_cnt_d  = eat_left + EW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_vsync_q <= 1'b0;
      success_p_q  <= 1'b0;
      input_p_q    <= 1'b0;
      tick_p_q     <= 1'b0;
      eat_cnt_q    <= '0;
      gap_q        <= '0;
      snd_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      prev_vsync_q <= prev_vsync_d;
      success_p_q  <= success_p_d;
      input_p_q    <= input_p_d;
      tick_p_q     <= tick_p_d;
      eat_cnt_q    <= eat_cnt_d;
      gap_q        <= gap_d;
      snd_q        <= snd_d;
      overflow_q   <= overflow_d;
    end
  end

  assign snd_failure   = snd_q[0];
  assign snd_success   = snd_q[1];
  assign snd_eat       = snd_q[2];
  assign snd_new_input = snd_q[3];
  assign snd_tick      = snd_q[4];
  assign busy          = (gap_q != '0);
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_sound_event_scheduler.sv
// Bench for sound_event_scheduler: frame-level reference model checked every cycle, directed scenarios, random traffic.
module tb_sound_event_scheduler;
  localparam int HL = 24;
  localparam int HS = 4;
  localparam int EM = 3;
  localparam int P  = 6;

  logic clk = 1'b0;
  logic rst, vsync, mute;
  logic ef, es, ee, ei, et;
  logic sf, ss, se, si, st, busy, ovf;

  sound_event_scheduler #(.HOLD_LONG(HL), .HOLD_SHORT(HS), .EAT_MAX(EM)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .mute(mute),
    .evt_failure(ef), .evt_success(es), .evt_eat(ee), .evt_new_input(ei), .evt_tick(et),
    .snd_failure(sf), .snd_success(ss), .snd_eat(se), .snd_new_input(si), .snd_tick(st),
    .busy(busy), .overflow(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: pending work and remaining reserved frames, as plain integers.
  int m_prev, m_succ, m_eat, m_inp, m_tick, m_gap;
  logic [4:0] exp_snd;
  logic       exp_ovf;
  int phase, edge_no, n_ovf, busy_edges;
  int n_snd[5];
  int last_edge[5];
  logic [4:0] dut_snd;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_succ = 0; m_eat = 0; m_inp = 0; m_tick = 0; m_gap = 0;
    exp_snd = '0; exp_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit edge_now;
    edge_now = (vsync == 1'b1) && (m_prev == 0);
    m_prev   = int'(vsync);
    if (edge_now) edge_no++;
    exp_snd = '0;
    exp_ovf = 1'b0;
    if (mute) begin
      m_succ = 0; m_eat = 0; m_inp = 0; m_tick = 0;
      if (edge_now && m_gap > 0) m_gap--;
    end else if (ef) begin
      m_succ = 0; m_eat = 0; m_inp = 0; m_tick = 0;
      m_gap = HL;
      exp_snd[0] = 1'b1;
    end else begin
      if (edge_now) begin
        if (m_gap > 0) m_gap--;
        else if (m_succ != 0) begin exp_snd[1] = 1'b1; m_succ = 0; m_gap = HL; end
        else if (m_eat > 0)   begin exp_snd[2] = 1'b1; m_eat--;    m_gap = HL; end
        else if (m_inp != 0)  begin exp_snd[3] = 1'b1; m_inp = 0;  m_gap = HS; end
        else if (m_tick != 0) begin exp_snd[4] = 1'b1; m_tick = 0; m_gap = HS; end
      end
      if (es) m_succ = 1;
      if (ei) m_inp = 1;
      if (et) m_tick = 1;
      if (ee) begin
        if (m_eat < EM) m_eat++;
        else exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    vsync = (phase < 2);
    if (vsync && m_prev == 0 && busy) busy_edges++;
    model_step();
    @(posedge clk);
    #1;
    phase = (phase + 1) % P;
    {ef, es, ee, ei, et} = '0;
    dut_snd = {st, si, se, ss, sf};
    check("snd_vector", int'(dut_snd), int'(exp_snd));
    check("overflow", int'(ovf), int'(exp_ovf));
    check("busy", int'(busy), (m_gap > 0) ? 1 : 0);
    for (int i = 0; i < 5; i++)
      if (dut_snd[i]) begin n_snd[i]++; last_edge[i] = edge_no; end
    if (ovf) n_ovf++;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n * P; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; mute = 1'b0; vsync = 1'b0;
    {ef, es, ee, ei, et} = '0;
    model_reset();
    edge_no = 0; n_ovf = 0; busy_edges = 0;
    for (int i = 0; i < 5; i++) begin n_snd[i] = 0; last_edge[i] = -1; end
    @(posedge clk);
    #1;
    rst = 1'b0;
    phase = 2;
  endtask

  initial begin
    do_reset();
    check("reset_snd", int'({st, si, se, ss, sf}), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overflow", int'(ovf), 0);

    // Single eat
    ee = 1'b1; cyc();
    run_frames(30);
    check("single_eat_count", n_snd[2], 1);
    check("single_eat_edge", last_edge[2], 1);
    check("single_eat_busy_edges", busy_edges, 24);

    // Four eats back to back
    do_reset();
    for (int i = 0; i < 4; i++) begin ee = 1'b1; cyc(); end
    run_frames(60);
    check("four_eat_overflow", n_ovf, 1);
    check("four_eat_count", n_snd[2], 3);
    check("four_eat_last_edge", last_edge[2], 51);
    check("four_eat_model_cnt", m_eat, 0);

    // Success and tick together
    do_reset();
    es = 1'b1; et = 1'b1; cyc();
    run_frames(35);
    check("succ_edge", last_edge[1], 1);
    check("tick_edge", last_edge[4], 26);
    check("tick_count", n_snd[4], 1);
    check("succ_tick_busy_edges", busy_edges, 28);

    // Failure during an eat gap
    do_reset();
    ee = 1'b1; cyc();
    run_frames(11);
    et = 1'b1; cyc();
    ef = 1'b1; cyc();
    check("fail_pulse", int'(sf), 1);
    busy_edges = 0;
    run_frames(30);
    check("fail_count", n_snd[0], 1);
    check("fail_tick_cleared", n_snd[4], 0);
    check("fail_busy_edges", busy_edges, 24);

    // Mute while busy
    do_reset();
    ee = 1'b1; cyc();
    run_frames(3);
    mute = 1'b1;
    ee = 1'b1; cyc();
    ef = 1'b1; cyc();
    es = 1'b1; cyc();
    run_frames(25);
    mute = 1'b0;
    run_frames(5);
    check("mute_total_snd", n_snd[0] + n_snd[1] + n_snd[2] + n_snd[3] + n_snd[4], 1);
    check("mute_busy_end", int'(busy), 0);

    // Asynchronous reset during the success pulse
    do_reset();
    es = 1'b1; cyc();
    for (int i = 0; i < 3 * P && !ss; i++) cyc();
    check("pre_reset_success", int'(ss), 1);
    rst = 1'b1;
    #1;
    check("async_rst_snd", int'({st, si, se, ss, sf}), 0);
    check("async_rst_busy", int'(busy), 0);
    do_reset();
    et = 1'b1; cyc();
    run_frames(6);
    check("post_rst_tick_edge", last_edge[4], 1);
    check("post_rst_tick_count", n_snd[4], 1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) mute = ~mute;
      ef = ($urandom_range(249) == 0);
      es = ($urandom_range(59) == 0);
      ee = ($urandom_range(14) == 0);
      ei = ($urandom_range(19) == 0);
      et = ($urandom_range(11) == 0);
      cyc();
    end
    mute = 1'b0;
    run_frames(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
